operand_sequencer: RTL
======================

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 1000: idle clock cycles allowed in ENT_B before entry is abandoned; legal range 2..65535.
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 key_digit  input  4  hex digit from the keypad decoder, valid while key_strobe is high.
REQ-006 key_strobe  input  1  level, high while a digit key is pressed.
REQ-007 key_enter  input  1  level, high while the enter key is pressed.
REQ-008 key_clear  input  1  level, high while the clear key is pressed.
REQ-009 op_ack  input  1  downstream ALU accepts the operand pair.
REQ-010 op_a  output  4  captured operand A; feeds display mux input A.
REQ-011 op_b  output  4  captured operand B; feeds display mux input B.
REQ-012 sel  output  1  display mux select: 0 = show op_a, 1 = show op_b.
REQ-013 op_valid  output  1  operand pair complete; held until acknowledged.
REQ-014 timeout_err  output  1  one-cycle pulse when ENT_B entry is abandoned.

Function
REQ-015 The block SHALL register key_strobe, key_enter and key_clear once; an event is a rising edge (current sample 1, previous sample 0); a held level SHALL count once.
REQ-016 All outputs SHALL be registered; an event sampled at edge k SHALL update outputs at edge k (visible in the following cycle), i.e. one-cycle latency from input rise.
REQ-017 The FSM SHALL have three states: ENT_A, ENT_B, DONE.
REQ-018 ENT_A: strobe event -> op_a <= key_digit (last digit wins); enter event -> ENT_B, sel <= 1.
REQ-019 ENT_B: strobe event -> op_b <= key_digit; enter event -> DONE, op_valid <= 1.
REQ-020 Strobe and enter events in the same cycle SHALL capture the digit into the current state's operand and take the enter transition in that same edge.
REQ-021 DONE: strobe and enter events SHALL be ignored; op_valid SHALL stay 1 until op_ack is sampled 1.
REQ-022 DONE with op_ack = 1 at edge k -> op_valid <= 0, sel <= 0, state ENT_A at edge k; op_a and op_b retain their values.
REQ-023 op_ack outside DONE SHALL be ignored.
REQ-024 A 16-bit idle counter SHALL run only in ENT_B, clear to 0 on entering ENT_B and on every strobe event in ENT_B, and saturate-free increment otherwise.
REQ-025 When the idle counter equals TIMEOUT-1 and no event occurs: state <= ENT_A, op_b <= 0, sel <= 0, timeout_err <= 1 for exactly one cycle; op_a retained.
REQ-026 A clear event SHALL take priority over all other events in any state: state <= ENT_A, op_a <= 0, op_b <= 0, sel <= 0, op_valid <= 0, counter <= 0, no timeout_err.
REQ-027 An enter event and timeout in the same ENT_B cycle SHALL resolve to the enter transition.
REQ-028 Events present during or immediately after reset deassertion SHALL be edge-detected against reset-value samples of 0.

Reset
REQ-029 rst_n low SHALL immediately force: state ENT_A, op_a 0, op_b 0, sel 0, op_valid 0, timeout_err 0, counter 0, edge-detect registers 0.
REQ-030 Reset asserted mid-entry or in DONE SHALL discard the pending pair with no op_valid or timeout_err pulse.

Verification
REQ-031 Digits 3 then 9 strobed in ENT_A, enter, digit 5, enter -> op_a 9, op_b 5, sel 1, op_valid 1, held until op_ack; then op_valid 0, sel 0.
REQ-032 key_strobe held high 20 cycles with digit 7, then digit changes to 2 while still high -> op_a 7, single capture.
REQ-033 TIMEOUT=8: enter into ENT_B, op_b 4, no keys for 8 cycles -> timeout_err single pulse, op_b 0, sel 0, op_a unchanged.
REQ-034 In DONE, strobe digit E and enter without op_ack -> op_a, op_b, op_valid unchanged.
REQ-035 Clear pressed in ENT_B with op_a 6, op_b 1 -> all outputs 0, state ENT_A; strobe+enter together in ENT_A with digit F -> op_a F, sel 1.
REQ-036 rst_n pulsed low mid-cycle while in DONE -> outputs 0 asynchronously, no op_valid after release.

Source files
------------

// File: rtl/operand_sequencer.sv
// Keypad operand sequencer: collects operand A then operand B from edge-detected
// key events, presents the pair to an ALU with a valid/ack handshake, and abandons stalled B entry.
module operand_sequencer #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_digit,
  input  logic       key_strobe,
  input  logic       key_enter,
  input  logic       key_clear,
  input  logic       op_ack,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       sel,
  output logic       op_valid,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    ENT_A = 2'd0,
    ENT_B = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic [3:0]  r_op_a;
  logic [3:0]  r_op_b;
  logic        r_sel;
  logic        r_op_valid;
  logic        r_timeout_err;
  logic [15:0] r_idle_cnt;

  logic        r_strobe_q;
  logic        r_enter_q;
  logic        r_clear_q;

  logic        w_strobe_ev;
  logic        w_enter_ev;
  logic        w_clear_ev;
  logic        w_idle_expired;

  // Previous-sample registers; a held key produces exactly one event.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strobe_q <= 1'b0;
      r_enter_q  <= 1'b0;
      r_clear_q  <= 1'b0;
    end else begin
      r_strobe_q <= key_strobe;
      r_enter_q  <= key_enter;
      r_clear_q  <= key_clear;
    end
  end

  assign w_strobe_ev    = key_strobe & ~r_strobe_q;
  assign w_enter_ev     = key_enter  & ~r_enter_q;
  assign w_clear_ev     = key_clear  & ~r_clear_q;
  assign w_idle_expired = (r_idle_cnt == IDLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ENT_A;
      r_op_a        <= 4'h0;
      r_op_b        <= 4'h0;
      r_sel         <= 1'b0;
      r_op_valid    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_idle_cnt    <= 16'd0;
    end else begin
      r_timeout_err <= 1'b0;
      if (w_clear_ev) begin
        r_state    <= ENT_A;
        r_op_a     <= 4'h0;
        r_op_b     <= 4'h0;
        r_sel      <= 1'b0;
        r_op_valid <= 1'b0;
        r_idle_cnt <= 16'd0;
      end else begin
        case (r_state)
          ENT_A: begin
            if (w_strobe_ev) r_op_a <= key_digit;
            if (w_enter_ev) begin
              r_state    <= ENT_B;
              r_sel      <= 1'b1;
              r_idle_cnt <= 16'd0;
            end
          end
          ENT_B: begin
            if (w_strobe_ev) r_op_b <= key_digit;
            // Enter wins over an expiring idle count in the same cycle.
            if (w_enter_ev) begin
              r_state    <= DONE;
              r_op_valid <= 1'b1;
              r_idle_cnt <= 16'd0;
            end else if (w_strobe_ev) begin
              r_idle_cnt <= 16'd0;
            end else if (w_idle_expired) begin
              r_state       <= ENT_A;
              r_op_b        <= 4'h0;
              r_sel         <= 1'b0;
              r_timeout_err <= 1'b1;
              r_idle_cnt    <= 16'd0;
            end else begin
              r_idle_cnt <= r_idle_cnt + 16'd1;
            end
          end
          DONE: begin
            if (op_ack) begin
              r_state    <= ENT_A;
              r_op_valid <= 1'b0;
              r_sel      <= 1'b0;
            end
          end
          default: begin
            r_state    <= ENT_A;
            r_sel      <= 1'b0;
            r_op_valid <= 1'b0;
            r_idle_cnt <= 16'd0;
          end
        endcase
      end
    end
  end

  assign op_a        = r_op_a;
  assign op_b        = r_op_b;
  assign sel         = r_sel;
  assign op_valid    = r_op_valid;
  assign timeout_err = r_timeout_err;

endmodule
